hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
Parametrised pipeline control block for the 5-stage RV32I core. It replaces the stall/flush-only hazard unit with the following:
- E-stage operand forwarding from M and W.
- A D-stage write-back bypass.
- Load-use interlock.
- A multi-cycle data-memory wait state machine, so the LSU can sit on synchronous SRAM with configurable latency.
- A saturating stall-cycle counter.

It sits beside the pipeline registers and drives every PC, IF/ID, ID/EX, EX/ME and ME/WB enable and flush signal.

Parameters:
AW, 5, register address width
FWD_EN, 1, 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling
LD_LAT, 1, extra cycles the M stage needs for a load or store (0..15)
CNT_W, 32, width of stall counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous, active-high reset (1 = reset)
rs1_addr_D, rs2_addr_D  in  AW  D-stage source registers
rs1_used_D, rs2_used_D  in  1  D-stage instruction reads rs1/rs2
rs1_addr_E, rs2_addr_E  in  AW  E-stage source registers
rd_addr_E, rd_addr_M, rd_addr_W  in  AW  destination registers per stage
rd_wren_E, rd_wren_M, rd_wren_W  in  1  stage writes rd
is_load_E, is_load_M  in  1  stage holds a load
mem_req_M  in  1  M stage holds a load or store
is_taken_E  in  1  branch/jump taken in E
pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable  out  1  register enables
IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush  out  1  insert bubble
fwd_a_sel, fwd_b_sel  out  2  E operand source: 00 regfile, 01 M ALU result, 10 W write-back data
byp_rs1_D, byp_rs2_D  out  1  D stage takes wb_data instead of regfile read
mem_busy  out  1  M stage waiting on memory
stall_cycles  out  CNT_W  count of cycles with pc_enable=0

Behaviour:
- Register address 0 never matches anything: no forward, bypass or stall.
- Forwarding (combinational), computed per operand a/b:
  - If FWD_EN and rd_wren_M and rd_M==rs_E and !is_load_M: sel=01.
  - Else if FWD_EN and rd_wren_W and rd_W==rs_E: sel=10.
  - Else: sel=00.
  - M has priority over W.
- byp_rsX_D = rsX_used_D & rd_wren_W & rd_W==rsX_D. This is independent of FWD_EN.
- data_stall condition:
  - FWD_EN=1: is_load_E & rd_wren_E & rd_E matches a used D source.
  - FWD_EN=0: a used D source matches rd_E (with rd_wren_E) or rd_M (with rd_wren_M).
- Memory FSM, states IDLE and WAIT, with 4-bit counter cnt:
  - LD_LAT=0: FSM stays in IDLE and mem_busy is always 0.
  - IDLE & mem_req_M: mem_busy=1; next state WAIT; cnt<=LD_LAT-1.
  - WAIT & cnt!=0: mem_busy=1; cnt<=cnt-1.
  - WAIT & cnt==0: mem_busy=0; next state IDLE, so the instruction advances this cycle.
  - Each M-stage memory op therefore occupies exactly LD_LAT+1 cycles. Back-to-back memory ops re-enter WAIT immediately.
- Output priority: reset > mem_busy > is_taken_E > data_stall > run.
  - mem_busy: pc, IF_ID, ID_EX and EX_ME enables=0; ME_WB_enable=1 with ME_WB_flush=1; all other flushes=0. A taken branch in E is held and redirects after the wait ends.
  - is_taken_E: all enables=1; IF_ID_flush=1 and ID_EX_flush=1. The pending data_stall is discarded.
  - data_stall: pc_enable=0, IF_ID_enable=0, ID_EX_flush=1; E, M and W advance.
  - run: all enables=1, all flushes=0.
- stall_cycles increments on every non-reset cycle with pc_enable=0 and saturates at all-ones.
- Reset (rst_n=1), effective the same cycle, including mid-WAIT:
  - state<=IDLE, cnt<=0, stall_cycles<=0.
  - Outputs while in reset: all flushes=1, all enables=1, pc_enable=0, fwd sels=00, byp=0, mem_busy=0.

Test Plan:
- FWD_EN=1: add x5 (M) followed by sub using x5 as rs1 (E) -> fwd_a_sel=01, no stall. Same case with the producer in W -> 10. Same case with rd=x0 -> 00.
- FWD_EN=1: lw x6 in E, D reads x6 as rs2 -> exactly one cycle with pc_enable=0 and ID_EX_flush=1. Next cycle: load in M, no stall. Consumer in E with load in W -> fwd_b_sel=10.
- LD_LAT=3: sw in M -> mem_busy high for 3 cycles, ME_WB_flush=1 for 3 cycles, advance on cycle 4, stall_cycles=3. Two consecutive loads -> 8 M-stage cycles in total.
- LD_LAT=2: load in M while a taken branch is in E -> no IF_ID/ID_EX flush for 2 cycles, then IF_ID_flush=ID_EX_flush=1 in the cycle mem_busy drops.
- FWD_EN=0: D reads x7 with rd_M=x7 -> stall until the producer leaves M. byp_rs1_D=1 when the producer reaches W. fwd sels stay 00 throughout.
- Reset asserted on the second WAIT cycle -> FSM in IDLE on release, mem_busy=0, stall_cycles=0, run mode next cycle. CNT_W=4 forced to 15 stall cycles -> counter holds at 15.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: pipeline control for the 5-stage RV32I core.
// It forwards E-stage operands from M and W, bypasses write-back data into D,
// and interlocks on load-use (or on any RAW hazard when forwarding is off).
// It holds the pipe while a data-memory access waits on a synchronous SRAM,
// and counts the cycles in which the PC was frozen.
module hazard_fwd_unit #(
  parameter int AW     = 5,
  parameter int FWD_EN = 1,
  parameter int LD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [AW-1:0]    rs1_addr_D,
  input  logic [AW-1:0]    rs2_addr_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,

  input  logic [AW-1:0]    rs1_addr_E,
  input  logic [AW-1:0]    rs2_addr_E,

  input  logic [AW-1:0]    rd_addr_E,
  input  logic [AW-1:0]    rd_addr_M,
  input  logic [AW-1:0]    rd_addr_W,
  input  logic             rd_wren_E,
  input  logic             rd_wren_M,
  input  logic             rd_wren_W,

  input  logic             is_load_E,
  input  logic             is_load_M,
  input  logic             mem_req_M,
  input  logic             is_taken_E,

  output logic             pc_enable,
  output logic             IF_ID_enable,
  output logic             ID_EX_enable,
  output logic             EX_ME_enable,
  output logic             ME_WB_enable,

  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_ME_flush,
  output logic             ME_WB_flush,

  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             byp_rs1_D,
  output logic             byp_rs2_D,

  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // Operand source encodings seen by the E-stage operand muxes.
  localparam logic [1:0] SelRegFile = 2'b00;
  localparam logic [1:0] SelMemAlu  = 2'b01;
  localparam logic [1:0] SelWbData  = 2'b10;

  // A memory op occupies LD_LAT+1 cycles in M: one cycle in IDLE to accept it,
  // LD_LAT-1 countdown cycles in WAIT, and the final release cycle.
  localparam bit         FwdOn   = (FWD_EN != 0);
  localparam bit         LatZero = (LD_LAT == 0);
  localparam int         LatM1   = (LD_LAT > 0) ? (LD_LAT - 1) : 0;
  localparam logic [3:0] CntLoad = LatM1[3:0];

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } memStateT;

  memStateT         memState_q, memState_d;
  logic [3:0]       memCnt_q, memCnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic       memBusy;
  logic [1:0] fwdA, fwdB;
  logic       bypRs1, bypRs2;
  logic       rs1HitE, rs2HitE, rs1HitM, rs2HitM;
  logic       dataStall;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic addrHit(input logic [AW-1:0] src,
                                   input logic [AW-1:0] dst,
                                   input logic          wren);
    return wren && (dst != '0) && (src == dst);
  endfunction

  // E-stage operand selection: the younger M result wins over W; a load in M
  // has no data yet, so its consumer falls through to W or the regfile.
  always_comb begin
    fwdA = SelRegFile;
    fwdB = SelRegFile;
    if (FwdOn) begin
      if (addrHit(rs1_addr_E, rd_addr_M, rd_wren_M) && !is_load_M) begin
        fwdA = SelMemAlu;
      end else if (addrHit(rs1_addr_E, rd_addr_W, rd_wren_W)) begin
        fwdA = SelWbData;
      end
      if (addrHit(rs2_addr_E, rd_addr_M, rd_wren_M) && !is_load_M) begin
        fwdB = SelMemAlu;
      end else if (addrHit(rs2_addr_E, rd_addr_W, rd_wren_W)) begin
        fwdB = SelWbData;
      end
    end
  end

  // D-stage bypass covers the regfile write/read collision in the same cycle;
  // it is needed even when E-stage forwarding is disabled.
  always_comb begin
    bypRs1 = rs1_used_D && addrHit(rs1_addr_D, rd_addr_W, rd_wren_W);
    bypRs2 = rs2_used_D && addrHit(rs2_addr_D, rd_addr_W, rd_wren_W);
  end

  // RAW interlock: with forwarding only a load in E must hold D; without it,
  // any producer still in E or M holds D until it reaches W.
  always_comb begin
    rs1HitE = rs1_used_D && addrHit(rs1_addr_D, rd_addr_E, rd_wren_E);
    rs2HitE = rs2_used_D && addrHit(rs2_addr_D, rd_addr_E, rd_wren_E);
    rs1HitM = rs1_used_D && addrHit(rs1_addr_D, rd_addr_M, rd_wren_M);
    rs2HitM = rs2_used_D && addrHit(rs2_addr_D, rd_addr_M, rd_wren_M);
    if (FwdOn) begin
      dataStall = is_load_E && (rs1HitE || rs2HitE);
    end else begin
      dataStall = rs1HitE || rs2HitE || rs1HitM || rs2HitM;
    end
  end

  // Memory wait FSM state register; reset returns to IDLE even mid-wait.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      memState_q <= MEM_IDLE;
      memCnt_q   <= 4'd0;
    end else begin
      memState_q <= memState_d;
      memCnt_q   <= memCnt_d;
    end
  end

  // Memory wait FSM next state: accept a request in IDLE, count down in WAIT.
  always_comb begin
    memState_d = memState_q;
    memCnt_d   = memCnt_q;
    if (!LatZero) begin
      case (memState_q)
        MEM_IDLE: begin
          if (mem_req_M) begin
            memState_d = MEM_WAIT;
            memCnt_d   = CntLoad;
          end
        end
        MEM_WAIT: begin
          if (memCnt_q != 4'd0) begin
            memCnt_d = memCnt_q - 4'd1;
          end else begin
            memState_d = MEM_IDLE;
          end
        end
        default: begin
          memState_d = MEM_IDLE;
          memCnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Memory wait FSM output: busy on acceptance and until the count runs out,
  // so the op is released in the cycle WAIT sees a zero count.
  always_comb begin
    memBusy = 1'b0;
    case (memState_q)
      MEM_IDLE: memBusy = !LatZero && mem_req_M;
      MEM_WAIT: memBusy = (memCnt_q != 4'd0);
      default:  memBusy = 1'b0;
    endcase
  end

  // Pipeline enables/flushes by priority: reset, memory wait, taken branch,
  // data interlock, free run. A branch seen during a wait is redirected once
  // the wait drops, because E is frozen and still holds it.
  always_comb begin
    pc_enable    = 1'b1;
    IF_ID_enable = 1'b1;
    ID_EX_enable = 1'b1;
    EX_ME_enable = 1'b1;
    ME_WB_enable = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_ME_flush  = 1'b0;
    ME_WB_flush  = 1'b0;
    fwd_a_sel    = fwdA;
    fwd_b_sel    = fwdB;
    byp_rs1_D    = bypRs1;
    byp_rs2_D    = bypRs2;
    mem_busy     = memBusy;
    if (rst_n) begin
      pc_enable   = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      EX_ME_flush = 1'b1;
      ME_WB_flush = 1'b1;
      fwd_a_sel   = SelRegFile;
      fwd_b_sel   = SelRegFile;
      byp_rs1_D   = 1'b0;
      byp_rs2_D   = 1'b0;
      mem_busy    = 1'b0;
    end else if (memBusy) begin
      pc_enable    = 1'b0;
      IF_ID_enable = 1'b0;
      ID_EX_enable = 1'b0;
      EX_ME_enable = 1'b0;
      ME_WB_flush  = 1'b1;
    end else if (is_taken_E) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (dataStall) begin
      pc_enable    = 1'b0;
      IF_ID_enable = 1'b0;
      ID_EX_flush  = 1'b1;
    end
  end

  // Stall counter next value: count frozen-PC cycles, stick at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (!pc_enable && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: three differently configured hazard units share one
// randomized input stream; a reference model queues expected outputs per cycle
// and a monitor pops and compares them on the falling edge.
module tb_hazard_fwd_unit;

  localparam int AW     = 5;
  localparam int NumDut = 3;
  localparam int FwdCfg  [NumDut] = '{1, 0, 0};
  localparam int LatCfg  [NumDut] = '{3, 0, 2};
  localparam int CntWCfg [NumDut] = '{32, 4, 8};
  localparam int RandCycles = 3000;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs1D;
    logic [AW-1:0] rs2D;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rs1E;
    logic [AW-1:0] rs2E;
    logic [AW-1:0] rdE;
    logic [AW-1:0] rdM;
    logic [AW-1:0] rdW;
    logic          wrE;
    logic          wrM;
    logic          wrW;
    logic          ldE;
    logic          ldM;
    logic          req;
    logic          taken;
  } stimT;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [5:0]  fwd;
    logic        busy;
    logic [31:0] cnt;
  } expT;

  typedef expT [NumDut-1:0] expAllT;

  logic clock;
  logic reset;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic rs1UsedD, rs2UsedD, wrE, wrM, wrW, loadE, loadM, memReqM, takenE;

  logic [NumDut-1:0] pcEn, ifIdEn, idExEn, exMeEn, meWbEn;
  logic [NumDut-1:0] ifIdFl, idExFl, exMeFl, meWbFl;
  logic [NumDut-1:0] byp1, byp2, memBusy;
  logic [NumDut-1:0][1:0] fwdA, fwdB;
  logic [31:0] stall0;
  logic [3:0]  stall1;
  logic [7:0]  stall2;

  expAllT expQ[$];
  int     age  [NumDut];
  longint cntM [NumDut];
  int     checks = 0;
  int     errors = 0;

  hazard_fwd_unit #(.AW(AW), .FWD_EN(FwdCfg[0]), .LD_LAT(LatCfg[0]), .CNT_W(CntWCfg[0])) dut0 (
    .clk(clock), .rst_n(reset),
    .rs1_addr_D(rs1D), .rs2_addr_D(rs2D), .rs1_used_D(rs1UsedD), .rs2_used_D(rs2UsedD),
    .rs1_addr_E(rs1E), .rs2_addr_E(rs2E),
    .rd_addr_E(rdE), .rd_addr_M(rdM), .rd_addr_W(rdW),
    .rd_wren_E(wrE), .rd_wren_M(wrM), .rd_wren_W(wrW),
    .is_load_E(loadE), .is_load_M(loadM), .mem_req_M(memReqM), .is_taken_E(takenE),
    .pc_enable(pcEn[0]), .IF_ID_enable(ifIdEn[0]), .ID_EX_enable(idExEn[0]),
    .EX_ME_enable(exMeEn[0]), .ME_WB_enable(meWbEn[0]),
    .IF_ID_flush(ifIdFl[0]), .ID_EX_flush(idExFl[0]), .EX_ME_flush(exMeFl[0]), .ME_WB_flush(meWbFl[0]),
    .fwd_a_sel(fwdA[0]), .fwd_b_sel(fwdB[0]), .byp_rs1_D(byp1[0]), .byp_rs2_D(byp2[0]),
    .mem_busy(memBusy[0]), .stall_cycles(stall0)
  );

  hazard_fwd_unit #(.AW(AW), .FWD_EN(FwdCfg[1]), .LD_LAT(LatCfg[1]), .CNT_W(CntWCfg[1])) dut1 (
    .clk(clock), .rst_n(reset),
    .rs1_addr_D(rs1D), .rs2_addr_D(rs2D), .rs1_used_D(rs1UsedD), .rs2_used_D(rs2UsedD),
    .rs1_addr_E(rs1E), .rs2_addr_E(rs2E),
    .rd_addr_E(rdE), .rd_addr_M(rdM), .rd_addr_W(rdW),
    .rd_wren_E(wrE), .rd_wren_M(wrM), .rd_wren_W(wrW),
    .is_load_E(loadE), .is_load_M(loadM), .mem_req_M(memReqM), .is_taken_E(takenE),
    .pc_enable(pcEn[1]), .IF_ID_enable(ifIdEn[1]), .ID_EX_enable(idExEn[1]),
    .EX_ME_enable(exMeEn[1]), .ME_WB_enable(meWbEn[1]),
    .IF_ID_flush(ifIdFl[1]), .ID_EX_flush(idExFl[1]), .EX_ME_flush(exMeFl[1]), .ME_WB_flush(meWbFl[1]),
    .fwd_a_sel(fwdA[1]), .fwd_b_sel(fwdB[1]), .byp_rs1_D(byp1[1]), .byp_rs2_D(byp2[1]),
    .mem_busy(memBusy[1]), .stall_cycles(stall1)
  );

  hazard_fwd_unit #(.AW(AW), .FWD_EN(FwdCfg[2]), .LD_LAT(LatCfg[2]), .CNT_W(CntWCfg[2])) dut2 (
    .clk(clock), .rst_n(reset),
    .rs1_addr_D(rs1D), .rs2_addr_D(rs2D), .rs1_used_D(rs1UsedD), .rs2_used_D(rs2UsedD),
    .rs1_addr_E(rs1E), .rs2_addr_E(rs2E),
    .rd_addr_E(rdE), .rd_addr_M(rdM), .rd_addr_W(rdW),
    .rd_wren_E(wrE), .rd_wren_M(wrM), .rd_wren_W(wrW),
    .is_load_E(loadE), .is_load_M(loadM), .mem_req_M(memReqM), .is_taken_E(takenE),
    .pc_enable(pcEn[2]), .IF_ID_enable(ifIdEn[2]), .ID_EX_enable(idExEn[2]),
    .EX_ME_enable(exMeEn[2]), .ME_WB_enable(meWbEn[2]),
    .IF_ID_flush(ifIdFl[2]), .ID_EX_flush(idExFl[2]), .EX_ME_flush(exMeFl[2]), .ME_WB_flush(meWbFl[2]),
    .fwd_a_sel(fwdA[2]), .fwd_b_sel(fwdB[2]), .byp_rs1_D(byp1[2]), .byp_rs2_D(byp2[2]),
    .mem_busy(memBusy[2]), .stall_cycles(stall2)
  );

  // Free-running clock, first rising edge at 5.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A register dependency exists only on a written, nonzero, equal address.
  function automatic bit depends(input logic [AW-1:0] rs, input logic [AW-1:0] rd, input logic wr);
    return wr && (rd != '0) && (rs == rd);
  endfunction

  function automatic logic [1:0] pickSrc(input logic [AW-1:0] rs, input stimT s, input int fwdEn);
    if (fwdEn == 0) return 2'b00;
    if (depends(rs, s.rdM, s.wrM) && !s.ldM) return 2'b01;
    if (depends(rs, s.rdW, s.wrW)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic longint maxCnt(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  // Reference behaviour for one cycle; age is how many cycles the current
  // M-stage memory op has already spent waiting.
  function automatic expT modelOut(input stimT s, input int fwdEn, input int lat,
                                   input int opAge, input longint cnt);
    expT e;
    bit pc, ifid, idex, exme, mewb, fIfid, fIdex, fExme, fMewb;
    bit busy, stall, eHit, mHit, p1, p2;
    logic [1:0] a, b;
    pc = 1; ifid = 1; idex = 1; exme = 1; mewb = 1;
    fIfid = 0; fIdex = 0; fExme = 0; fMewb = 0;
    a = pickSrc(s.rs1E, s, fwdEn);
    b = pickSrc(s.rs2E, s, fwdEn);
    p1 = s.u1 && depends(s.rs1D, s.rdW, s.wrW);
    p2 = s.u2 && depends(s.rs2D, s.rdW, s.wrW);
    eHit = (s.u1 && depends(s.rs1D, s.rdE, s.wrE)) || (s.u2 && depends(s.rs2D, s.rdE, s.wrE));
    mHit = (s.u1 && depends(s.rs1D, s.rdM, s.wrM)) || (s.u2 && depends(s.rs2D, s.rdM, s.wrM));
    stall = (fwdEn != 0) ? (s.ldE && eHit) : (eHit || mHit);
    busy = (lat > 0) && s.req && (opAge < lat);
    if (s.rst) begin
      pc = 0; fIfid = 1; fIdex = 1; fExme = 1; fMewb = 1;
      a = 2'b00; b = 2'b00; p1 = 0; p2 = 0; busy = 0;
    end else if (busy) begin
      pc = 0; ifid = 0; idex = 0; exme = 0; fMewb = 1;
    end else if (s.taken) begin
      fIfid = 1; fIdex = 1;
    end else if (stall) begin
      pc = 0; ifid = 0; fIdex = 1;
    end
    e.ctrl = {pc, ifid, idex, exme, mewb, fIfid, fIdex, fExme, fMewb};
    e.fwd  = {a, b, p1, p2};
    e.busy = busy;
    e.cnt  = 32'(cnt);
    return e;
  endfunction

  // Drive one cycle of inputs, queue what every configuration must answer,
  // then advance the model's wait age and stall count.
  task automatic applyStimulus(input stimT s);
    expAllT e;
    reset = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; rs1UsedD = s.u1; rs2UsedD = s.u2;
    rs1E = s.rs1E; rs2E = s.rs2E; rdE = s.rdE; rdM = s.rdM; rdW = s.rdW;
    wrE = s.wrE; wrM = s.wrM; wrW = s.wrW; loadE = s.ldE; loadM = s.ldM;
    memReqM = s.req; takenE = s.taken;
    for (int i = 0; i < NumDut; i++) begin
      e[i] = modelOut(s, FwdCfg[i], LatCfg[i], age[i], cntM[i]);
      if (s.rst) begin
        age[i]  = 0;
        cntM[i] = 0;
      end else begin
        age[i] = e[i].busy ? age[i] + 1 : 0;
        if (!e[i].ctrl[8] && cntM[i] < maxCnt(CntWCfg[i])) cntM[i]++;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic step(input stimT s);
    @(posedge clock);
    #1;
    applyStimulus(s);
  endtask

  function automatic logic coin(input int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  function automatic logic [AW-1:0] randReg();
    return AW'($urandom_range(0, 3));
  endfunction

  // Random cycle; the M-stage op stays put while any configuration waits on it.
  function automatic stimT randStim();
    stimT s;
    bit holdM;
    s.rst  = coin(60);
    s.rs1D = randReg(); s.rs2D = randReg();
    s.u1   = !coin(4);  s.u2   = !coin(4);
    s.rs1E = randReg(); s.rs2E = randReg();
    s.rdE  = randReg(); s.rdM  = randReg(); s.rdW = randReg();
    s.wrE  = !coin(4);  s.wrM  = !coin(4);  s.wrW = !coin(4);
    s.ldE  = coin(2);   s.ldM  = coin(2);
    s.req  = coin(4);   s.taken = coin(6);
    holdM = 0;
    for (int i = 0; i < NumDut; i++) if (age[i] > 0) holdM = 1;
    if (holdM) s.req = 1'b1;
    return s;
  endfunction

  task automatic checkField(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d t=%0t actual=%h expected=%h", name, idx, $time, act, exp);
    end
  endtask

  // Compare every configuration's outputs against the queued expectation.
  task automatic checkOutput(input expAllT e);
    logic [8:0]  ctrl;
    logic [5:0]  fwd;
    logic [31:0] cnt;
    for (int i = 0; i < NumDut; i++) begin
      ctrl = {pcEn[i], ifIdEn[i], idExEn[i], exMeEn[i], meWbEn[i],
              ifIdFl[i], idExFl[i], exMeFl[i], meWbFl[i]};
      fwd  = {fwdA[i], fwdB[i], byp1[i], byp2[i]};
      cnt  = (i == 0) ? stall0 : (i == 1) ? 32'(stall1) : 32'(stall2);
      checkField("ctrl", i, 32'(ctrl), 32'(e[i].ctrl));
      checkField("fwd_byp", i, 32'(fwd), 32'(e[i].fwd));
      checkField("mem_busy", i, 32'(memBusy[i]), 32'(e[i].busy));
      checkField("stall_cycles", i, cnt, e[i].cnt);
    end
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Stimulus: reset, directed hazard scenarios, then a random stream.
  initial begin
    stimT s;
    for (int i = 0; i < NumDut; i++) begin
      age[i]  = 0;
      cntM[i] = 0;
    end
    s = '0;
    s.rst = 1'b1;
    reset = 1'b1; rs1D = '0; rs2D = '0; rs1UsedD = 0; rs2UsedD = 0;
    rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    wrE = 0; wrM = 0; wrW = 0; loadE = 0; loadM = 0; memReqM = 0; takenE = 0;
    repeat (2) step(s);

    // D reads x7 while its producer sits in M: forwarding-off units stall long
    // enough to saturate the narrow counter.
    s = '0; s.rs1D = AW'(7); s.u1 = 1; s.rdM = AW'(7); s.wrM = 1;
    repeat (20) step(s);
    // Producer reaches W: D takes the bypass.
    s = '0; s.rs1D = AW'(7); s.u1 = 1; s.rdW = AW'(7); s.wrW = 1;
    step(s);
    // E operands: rs1 from M, rs2 from W, and a write to x0 that must not match.
    s = '0; s.rs1E = AW'(5); s.rdM = AW'(5); s.wrM = 1; s.rs2E = AW'(6); s.rdW = AW'(6); s.wrW = 1;
    step(s);
    s = '0; s.rs1E = AW'(0); s.rdM = AW'(0); s.wrM = 1; s.rs1D = AW'(0); s.u1 = 1;
    step(s);
    // Load x6 in E, D reads x6 as rs2.
    s = '0; s.ldE = 1; s.wrE = 1; s.rdE = AW'(6); s.rs2D = AW'(6); s.u2 = 1;
    step(s);
    // Load in M while a taken branch waits in E.
    s = '0; s.req = 1; s.ldM = 1; s.taken = 1;
    repeat (4) step(s);
    // Reset lands on the second WAIT cycle, then plain run.
    s = '0; s.req = 1;
    repeat (2) step(s);
    s.rst = 1;
    step(s);
    s = '0;
    repeat (2) step(s);

    for (int n = 0; n < RandCycles; n++) step(randStim());

    @(negedge clock);
    #1;
    for (int k = 0; k < 10 && expQ.size() != 0; k++) @(negedge clock);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
